int_ctrl: RTL and testbench
===========================

Name: int_ctrl

Overview:
Game Boy interrupt controller. It collects one-cycle request pulses from the joypad, timer, serial, LCD STAT and VBlank blocks into IF (0xFF0F), masks them with IE (0xFFFF), and arbitrates by fixed priority. It presents a single request/vector to the CPU and clears the serviced IF bit on the CPU's acknowledge handshake. It sits between the peripheral interrupt outputs (e.g. joy_int) and the CPU core, on the shared memory-mapped bus.

Parameters:
IF_ADDR, 16'hFF0F, address of the IF register
IE_ADDR, 16'hFFFF, address of the IE register
NUM_SRC, 5, number of interrupt sources (bit 0 = highest priority)

Ports:
clockgb  input  1  system clock; all state updates on posedge
resetn  input  1  asynchronous active-low reset
address  input  16  CPU bus address
indata  input  8  CPU write data
outdata  output  8  CPU read data; 0 when neither register is addressed
load  input  1  CPU read strobe
store  input  1  CPU write strobe, one cycle per write
vblank_int  input  1  source 0 pulse
lcd_int  input  1  source 1 pulse
timer_int  input  1  source 2 pulse
serial_int  input  1  source 3 pulse
joy_int  input  1  source 4 pulse
int_req  output  1  registered request to the CPU dispatcher
int_vector  output  8  low byte of the ISR address: 0x40 + 8*index; upper byte is 0x00
int_ack  input  1  one-cycle pulse, CPU has taken the vector
wake  output  1  combinational |(IF & IE[4:0]); for HALT exit, independent of state

Behaviour:
- Reset (async, resetn=0): IF=0, IE=0, state=IDLE, int_req=0, int_vector=0x40, latched index=0.
- IF is 5 bits of storage.
  - Read returns {3'b111, IF}.
  - A store to IF_ADDR writes indata[4:0].
- IE is 8 bits of storage, read/written in full. Only IE[4:0] take part in arbitration.
- Reads: outdata is combinational from address and load, with zero wait states.
- IF next-state per bit i, applied in this order:
  1. Start from the current value.
  2. Apply a CPU write, if any.
  3. Clear the bit if an ack targets index i.
  4. Set the bit if source i pulses.
  - Result: a source set always wins over a same-cycle write-clear or ack-clear.
- pending = IF & IE[4:0]. sel = index of the lowest set bit of pending.
- State machine, two states, registered:
  - IDLE: int_req=0. If pending != 0, latch sel into idx, set int_vector=0x40+{idx,3'b0}, go to GRANT. Request latency from source pulse (IE set) to int_req=1 is 2 clocks: IF sets at edge 1, GRANT entered at edge 2.
  - GRANT: int_req=1; int_vector is held stable for the whole state.
    - int_ack=1: clear IF[idx] (subject to the set-wins rule above), go to IDLE. int_req is low for at least one cycle before re-arbitration.
    - int_ack=0 and pending[idx] has been cleared (by a CPU write to IF or IE): go to IDLE with no IF change (request withdrawn).
    - A higher-priority source arriving during GRANT does NOT preempt. It is served on the next IDLE->GRANT pass.
  - int_ack while in IDLE: ignored, no IF change.
- Source pulses longer than one cycle simply keep the IF bit set; they are not counted.
- Reset asserted mid-GRANT: immediate return to reset values. The pending request is lost.

Decomposition:
- Shared package gb_pkg:
  - IF_ADDR/IE_ADDR constants
  - source index constants INT_VBLANK=0, INT_LCD=1, INT_TIMER=2, INT_SERIAL=3, INT_JOY=4
  - INT_VEC_BASE=8'h40
  - two-state enum {IDLE, GRANT}
- Register access uses two rrmmap instances, one at IF_ADDR and one at IE_ADDR; their outdata are ORed.
- Natural sub-module: int_prio_enc. Combinational: 5-bit pending in -> 3-bit index + any flag.

Test Plan:
- Reset, then read 0xFF0F and 0xFFFF -> 0xE0 and 0x00; int_req=0, wake=0.
- IE=0x1F, pulse joy_int -> IF reads 0xF0 next cycle; int_req=1 two clocks after the pulse, int_vector=0x60; int_ack -> IF reads 0xE0, int_req=0.
- IE=0x1F, pulse timer_int and vblank_int together -> first grant vector 0x40; after ack, one idle cycle, then grant 0x50; after ack, IF=0xE0.
- IE=0x00, pulse serial_int -> IF=0xE8, wake=0, int_req stays 0; then write IE=0x08 -> wake=1 immediately, int_req=1 two clocks later, vector 0x58.
- In GRANT on vector 0x48, write IF=0x00 with no ack -> int_req drops next cycle, no grant follows. Repeat with lcd_int pulsing in the same cycle as the write -> IF bit 1 stays set, re-grant 0x48.
- In GRANT on 0x60, int_ack and joy_int in the same cycle -> IF bit 4 stays set, int_req re-asserts with 0x60 after one idle cycle. Assert resetn=0 mid-GRANT -> int_req=0 and IF=0 asynchronously.

Source files
------------

// File: rtl/gb_pkg.sv
// Shared Game Boy interrupt definitions: register addresses, source indices, vector base.
// No logic.
// No flow control.
package gb_pkg;

    localparam logic [15:0] IF_ADDR      = 16'hFF0F;
    localparam logic [15:0] IE_ADDR      = 16'hFFFF;
    localparam int          NUM_SRC      = 5;

    localparam int          INT_VBLANK   = 0;
    localparam int          INT_LCD      = 1;
    localparam int          INT_TIMER    = 2;
    localparam int          INT_SERIAL   = 3;
    localparam int          INT_JOY      = 4;

    localparam logic [7:0]  INT_VEC_BASE = 8'h40;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } int_state_t;

    // ISR entry points are spaced 8 bytes apart starting at the base.
    function automatic logic [7:0] int_vec(input logic [2:0] idx);
        return INT_VEC_BASE + {2'b00, idx, 3'b000};
    endfunction

endpackage

// File: rtl/int_prio_enc.sv
// Fixed-priority encoder: lowest set pending bit wins.
// Latency: combinational.
// Backpressure: none.
module int_prio_enc
    import gb_pkg::*;
(
    input  logic [NUM_SRC-1:0] pending,
    output logic [2:0]         idx,
    output logic               any
);

    always_comb begin
        idx = 3'd0;
        for (int i = NUM_SRC - 1; i >= 0; i--) begin
            if (pending[i]) begin
                idx = 3'(i);
            end
        end
    end

    assign any = |pending;

endmodule

// File: rtl/rrmmap.sv
// Address decode for one memory-mapped byte register: read mux and write enable.
// Latency: combinational, zero wait states.
// Backpressure: none; the bus is never stalled.
module rrmmap #(
    parameter logic [15:0] ADDR = 16'h0000
) (
    input  logic [15:0] address,
    input  logic        load,
    input  logic        store,
    input  logic [7:0]  rdval,
    output logic [7:0]  outdata,
    output logic        wr_en
);

    logic hit;

    assign hit     = (address == ADDR);
    assign outdata = (hit && load) ? rdval : 8'h00;
    assign wr_en   = hit && store;

endmodule

// File: rtl/int_ctrl.sv
// Interrupt controller: IF/IE registers, fixed-priority arbitration, request/ack to CPU.
// Latency: source pulse to int_req is 2 clocks; bus reads are combinational.
// Backpressure: a granted request holds until int_ack or withdrawal; no preemption.
module int_ctrl
    import gb_pkg::*;
(
    input  logic        clockgb,
    input  logic        resetn,
    input  logic [15:0] address,
    input  logic [7:0]  indata,
    output logic [7:0]  outdata,
    input  logic        load,
    input  logic        store,
    input  logic        vblank_int,
    input  logic        lcd_int,
    input  logic        timer_int,
    input  logic        serial_int,
    input  logic        joy_int,
    output logic        int_req,
    output logic [7:0]  int_vector,
    input  logic        int_ack,
    output logic        wake
);

    logic [NUM_SRC-1:0] if_q;
    logic [NUM_SRC-1:0] if_nxt;
    logic [NUM_SRC-1:0] src;
    logic [NUM_SRC-1:0] pending;
    logic [7:0]         ie_q;
    int_state_t         state_q;
    int_state_t         state_nxt;
    logic [2:0]         idx_q;
    logic [2:0]         sel;
    logic               any;
    logic               grant_go;
    logic               ack_clr;
    logic               if_wr;
    logic               ie_wr;
    logic [7:0]         if_out;
    logic [7:0]         ie_out;
    logic [7:0]         vec_q;

    always_comb begin
        src             = '0;
        src[INT_VBLANK] = vblank_int;
        src[INT_LCD]    = lcd_int;
        src[INT_TIMER]  = timer_int;
        src[INT_SERIAL] = serial_int;
        src[INT_JOY]    = joy_int;
    end

    assign pending    = if_q & ie_q[NUM_SRC-1:0];
    assign wake       = |pending;
    assign int_req    = (state_q == GRANT);
    assign int_vector = vec_q;

    int_prio_enc u_prio (
        .pending (pending),
        .idx     (sel),
        .any     (any)
    );

    rrmmap #(.ADDR(IF_ADDR)) u_if_map (
        .address (address),
        .load    (load),
        .store   (store),
        .rdval   ({3'b111, if_q}),
        .outdata (if_out),
        .wr_en   (if_wr)
    );

    rrmmap #(.ADDR(IE_ADDR)) u_ie_map (
        .address (address),
        .load    (load),
        .store   (store),
        .rdval   (ie_q),
        .outdata (ie_out),
        .wr_en   (ie_wr)
    );

    assign outdata = if_out | ie_out;

    always_comb begin
        state_nxt = state_q;
        grant_go  = 1'b0;
        ack_clr   = 1'b0;
        case (state_q)
            IDLE: begin
                if (any) begin
                    grant_go  = 1'b1;
                    state_nxt = GRANT;
                end
            end
            GRANT: begin
                // Ack takes precedence; otherwise drop the request if software cleared it.
                if (int_ack) begin
                    ack_clr   = 1'b1;
                    state_nxt = IDLE;
                end else if (!pending[idx_q]) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Ordering makes a same-cycle source pulse win over write-clear and ack-clear.
    always_comb begin
        if_nxt = if_q;
        if (if_wr) begin
            if_nxt = indata[NUM_SRC-1:0];
        end
        if (ack_clr) begin
            if_nxt[idx_q] = 1'b0;
        end
        if_nxt = if_nxt | src;
    end

    always_ff @(posedge clockgb or negedge resetn) begin
        if (!resetn) begin
            state_q <= IDLE;
            idx_q   <= 3'd0;
            vec_q   <= INT_VEC_BASE;
            if_q    <= '0;
            ie_q    <= 8'h00;
        end else begin
            state_q <= state_nxt;
            if_q    <= if_nxt;
            if (grant_go) begin
                idx_q <= sel;
                vec_q <= int_vec(sel);
            end
            if (ie_wr) begin
                ie_q <= indata;
            end
        end
    end

endmodule

// File: tb/tb_int_ctrl.sv
// Scoreboard bench for int_ctrl: stimulus queues expectations, a negedge monitor checks them.
module tb_int_ctrl;

    logic        clockgb = 1'b0;
    logic        resetn  = 1'b0;
    logic [15:0] address = 16'h0000;
    logic [7:0]  indata  = 8'h00;
    logic [7:0]  outdata;
    logic        load = 1'b0;
    logic        store = 1'b0;
    logic        vblank_int = 1'b0;
    logic        lcd_int = 1'b0;
    logic        timer_int = 1'b0;
    logic        serial_int = 1'b0;
    logic        joy_int = 1'b0;
    logic        int_req;
    logic [7:0]  int_vector;
    logic        int_ack = 1'b0;
    logic        wake;

    localparam logic [15:0] A_IF = 16'hFF0F;
    localparam logic [15:0] A_IE = 16'hFFFF;

    typedef struct {
        logic [7:0] vec;
        int         cyc;
    } gr_t;

    typedef struct {
        logic       req;
        logic       wake;
        logic [7:0] vec;
        logic       cv;
    } st_t;

    logic [7:0] rd_q[$];
    gr_t        gr_q[$];
    st_t        st_q[$];
    logic       chk_stb = 1'b0;
    logic       req_prev = 1'b0;
    int         cyc = 0;
    int         total = 0;
    int         bad = 0;

    int_ctrl dut (
        .clockgb    (clockgb),
        .resetn     (resetn),
        .address    (address),
        .indata     (indata),
        .outdata    (outdata),
        .load       (load),
        .store      (store),
        .vblank_int (vblank_int),
        .lcd_int    (lcd_int),
        .timer_int  (timer_int),
        .serial_int (serial_int),
        .joy_int    (joy_int),
        .int_req    (int_req),
        .int_vector (int_vector),
        .int_ack    (int_ack),
        .wake       (wake)
    );

    always #5 clockgb = ~clockgb;

    always @(posedge clockgb) cyc <= cyc + 1;

    // Monitor: compare whatever the DUT presents against the oldest queued expectation.
    always @(negedge clockgb) begin
        if (load) begin
            total++;
            if (rd_q.size() == 0) begin
                bad++;
                $display("FAIL rd_unexpected addr=%h got=%h", address, outdata);
            end else begin
                logic [7:0] e;
                e = rd_q.pop_front();
                if (outdata !== e) begin
                    bad++;
                    $display("FAIL rd addr=%h cyc=%0d got=%h want=%h", address, cyc, outdata, e);
                end
            end
        end
        if (chk_stb) begin
            total++;
            if (st_q.size() == 0) begin
                bad++;
                $display("FAIL st_unexpected cyc=%0d", cyc);
            end else begin
                st_t s;
                s = st_q.pop_front();
                if (int_req !== s.req || wake !== s.wake || (s.cv && int_vector !== s.vec)) begin
                    bad++;
                    $display("FAIL st cyc=%0d got req=%b wake=%b vec=%h want req=%b wake=%b vec=%h",
                             cyc, int_req, wake, int_vector, s.req, s.wake, s.vec);
                end
            end
        end
        if (int_req === 1'b1 && req_prev === 1'b0) begin
            total++;
            if (gr_q.size() == 0) begin
                bad++;
                $display("FAIL grant_unexpected cyc=%0d vec=%h", cyc, int_vector);
            end else begin
                gr_t g;
                g = gr_q.pop_front();
                if (int_vector !== g.vec || cyc != g.cyc) begin
                    bad++;
                    $display("FAIL grant got vec=%h cyc=%0d want vec=%h cyc=%0d",
                             int_vector, cyc, g.vec, g.cyc);
                end
            end
        end
        req_prev = int_req;
    end

    task automatic step();
        @(posedge clockgb);
        #1;
        store = 1'b0; load = 1'b0; int_ack = 1'b0; chk_stb = 1'b0;
        {joy_int, serial_int, timer_int, lcd_int, vblank_int} = 5'b0;
    endtask

    task automatic do_wr(input logic [15:0] a, input logic [7:0] d);
        address = a; indata = d; store = 1'b1;
    endtask

    task automatic do_rd(input logic [15:0] a, input logic [7:0] e);
        address = a; load = 1'b1; rd_q.push_back(e);
    endtask

    task automatic do_src(input logic [4:0] m);
        {joy_int, serial_int, timer_int, lcd_int, vblank_int} = m;
    endtask

    task automatic do_ack();
        int_ack = 1'b1;
    endtask

    task automatic do_chk(input logic r, input logic w, input logic [7:0] v, input logic cv);
        st_t s;
        s.req = r; s.wake = w; s.vec = v; s.cv = cv;
        st_q.push_back(s);
        chk_stb = 1'b1;
    endtask

    task automatic exp_grant(input logic [7:0] v, input int dly);
        gr_t g;
        g.vec = v; g.cyc = cyc + dly;
        gr_q.push_back(g);
    endtask

    initial begin
        step(); step();
        resetn = 1'b1;

        // Reset values
        do_rd(A_IF, 8'hE0); do_chk(1'b0, 1'b0, 8'h40, 1'b1); step();
        do_rd(A_IE, 8'h00); step();

        // Single joypad interrupt
        do_wr(A_IE, 8'h1F); step();
        do_src(5'b10000); exp_grant(8'h60, 2); step();
        do_rd(A_IF, 8'hF0); do_chk(1'b0, 1'b1, 8'h40, 1'b1); step();
        do_chk(1'b1, 1'b1, 8'h60, 1'b1); do_ack(); step();
        do_rd(A_IF, 8'hE0); do_chk(1'b0, 1'b0, 8'h00, 1'b0); step();

        // Timer and VBlank together: VBlank first, then timer after an idle cycle
        do_src(5'b00101); exp_grant(8'h40, 2); step();
        step();
        do_ack(); exp_grant(8'h50, 2); step();
        do_chk(1'b0, 1'b1, 8'h00, 1'b0); step();
        do_ack(); step();
        do_rd(A_IF, 8'hE0); do_chk(1'b0, 1'b0, 8'h00, 1'b0); step();

        // Serial masked, ack in IDLE ignored, then unmask
        do_wr(A_IE, 8'h00); step();
        do_src(5'b01000); step();
        do_rd(A_IF, 8'hE8); do_chk(1'b0, 1'b0, 8'h00, 1'b0); do_ack(); step();
        do_rd(A_IF, 8'hE8); do_chk(1'b0, 1'b0, 8'h00, 1'b0); step();
        do_wr(A_IE, 8'h08); exp_grant(8'h58, 2); step();
        do_chk(1'b0, 1'b1, 8'h00, 1'b0); do_rd(A_IE, 8'h08); step();
        do_ack(); step();
        do_chk(1'b0, 1'b0, 8'h00, 1'b0); step();

        // Withdrawal by IF write during GRANT
        do_wr(A_IE, 8'h1F); step();
        do_src(5'b00010); exp_grant(8'h48, 2); step();
        step();
        do_wr(A_IF, 8'h00); step();
        do_chk(1'b1, 1'b0, 8'h48, 1'b1); step();
        do_chk(1'b0, 1'b0, 8'h00, 1'b0); step();
        do_chk(1'b0, 1'b0, 8'h00, 1'b0); step();

        // Same-cycle LCD pulse beats the IF clear; request stays on 0x48
        do_src(5'b00010); exp_grant(8'h48, 2); step();
        step();
        do_wr(A_IF, 8'h00); do_src(5'b00010); step();
        do_rd(A_IF, 8'hE2); do_chk(1'b1, 1'b1, 8'h48, 1'b1); step();
        do_chk(1'b1, 1'b1, 8'h48, 1'b1); do_ack(); step();
        do_rd(A_IF, 8'hE0); do_chk(1'b0, 1'b0, 8'h00, 1'b0); step();

        // Ack and joypad pulse together: bit stays set, re-grant after one idle cycle
        do_src(5'b10000); exp_grant(8'h60, 2); step();
        step();
        do_ack(); do_src(5'b10000); exp_grant(8'h60, 2); step();
        do_rd(A_IF, 8'hF0); do_chk(1'b0, 1'b1, 8'h00, 1'b0); step();
        do_chk(1'b1, 1'b1, 8'h60, 1'b1); step();

        // Asynchronous reset in the middle of GRANT
        resetn = 1'b0;
        do_rd(A_IF, 8'hE0); do_chk(1'b0, 1'b0, 8'h40, 1'b1); step();
        do_rd(A_IE, 8'h00); step();
        resetn = 1'b1;
        do_chk(1'b0, 1'b0, 8'h40, 1'b1); step();
        step(); step();

        total++;
        if (gr_q.size() != 0 || rd_q.size() != 0 || st_q.size() != 0) begin
            bad++;
            $display("FAIL leftover got gr=%0d rd=%0d st=%0d want 0 0 0",
                     gr_q.size(), rd_q.size(), st_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
